fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Sequences the core's instruction supply. It replaces the toggled core clock with a single-clock enable pulse, drives the instruction address `pointer` to external instruction memory, and captures `instr_in` after a fixed memory latency. It then hands the word to the core through a valid/ready handshake and handles redirects (branches) and halt. It sits in `top` between the instruction memory pins and the core.

Parameters:
ADDR_W, 32, width of `pointer` / `redirect_addr`; word-addressed.
DIV, 4, `core_en` period in clk cycles; legal range is 2 or more.
MEM_LAT, 1, clk cycles from the ISSUE cycle to `instr_in` valid; legal range is 1 or more.
RESET_ADDR, 0, `pointer` value after reset.

Ports:
clk  in  1  system clock; all logic on posedge.
_reset  in  1  synchronous, active-low reset.
instr_in  in  32  instruction word from memory.
pointer  out  ADDR_W  instruction address to memory.
core_en  out  1  one-cycle core step enable, every DIV cycles.
instr_out  out  32  latched instruction to core.
instr_valid  out  1  `instr_out` is valid.
instr_ready  in  1  core accepts the instruction.
redirect  in  1  branch/jump request.
redirect_addr  in  ADDR_W  redirect target.
halt  in  1  stop fetching.
halted  out  1  controller is halted.

Behaviour:
- Reset applies on any posedge with `_reset`=0:
  - pointer=RESET_ADDR, state=IDLE.
  - instr_out=0, instr_valid=0, halted=0.
  - Divider count=0, core_en=0.
  - Reset mid-fetch abandons the fetch, with no output glitch beyond the reset values.
- Divider is free-running and independent of state:
  - cnt counts 0..DIV-1 and wraps.
  - core_en=1 exactly when cnt==DIV-1 (registered).
  - First pulse occurs in the DIV-th cycle after reset release.
- Core inputs (instr_ready, redirect, halt) are sampled only in cycles with core_en=1.
- Transfer = instr_valid & instr_ready & core_en.
- FSM states: IDLE, ISSUE, WAIT, HOLD, HALTED. Transitions:
  - IDLE: lasts 1 cycle, then ISSUE.
  - ISSUE: `pointer` is stable; load lat_cnt=MEM_LAT; go to WAIT.
  - WAIT: decrement lat_cnt each cycle. In the cycle where lat_cnt==1, capture `instr_in` into `instr_out` and go to HOLD; instr_valid=1 from the first HOLD cycle.
  - HOLD: hold `instr_out`/`instr_valid` stable until transfer. On transfer: pointer<=pointer+1 (wraps 2^ADDR_W-1 to 0), instr_valid<=0, go to ISSUE.
  - HALTED: instr_valid=0, halted=1, pointer frozen. Leave only by reset.
- Latency:
  - First instr_valid occurs in cycle 2+MEM_LAT after reset release (IDLE=cycle 0).
  - Each subsequent fetch takes 1+MEM_LAT cycles after the transfer cycle.
- Priority when core_en=1: halt > redirect > transfer.
  - halt=1 in any state: go to HALTED next cycle; drop any in-flight fetch and any held word.
  - redirect=1 (no halt) in ISSUE/WAIT/HOLD:
    - pointer<=redirect_addr, instr_valid<=0, go to ISSUE.
    - An in-flight WAIT capture is discarded; `instr_out` keeps its old value.
    - If a transfer also occurs in that cycle, the transfer completes (the core consumed the word) and the next fetch goes to redirect_addr, not pointer+1.
  - redirect in IDLE: pointer<=redirect_addr; state still proceeds to ISSUE.
- Ignored inputs:
  - instr_ready is ignored when instr_valid=0.
  - Inputs in cycles with core_en=0 have no effect.
- `pointer` changes only on:
  - reset
  - transfer (+1)
  - accepted redirect

Decomposition:
- Package `fetch_pkg`:
  - typedef enum logic[2:0] fetch_state_t {IDLE, ISSUE, WAIT, HOLD, HALTED}
  - localparam INSTR_W=32
  - default constants for DIV/MEM_LAT
- Sub-module `clk_en_div` (params DIV; ports clk, _reset, en): the free-running enable-pulse generator, reusable for other slow-domain blocks.
- `fetch_ctrl` contains the FSM, latency counter and address register.

Test Plan:
1. DIV=4, MEM_LAT=1, RESET_ADDR=0; release reset; instr_in=32'hA0000001 when pointer==0 -> core_en pulses in cycles 3,7,11…; pointer=0; instr_valid=1 from cycle 3 with instr_out=32'hA0000001; halted=0.
2. Hold instr_ready=1 and feed instr_in=pointer+32'h100 -> one transfer per core_en once valid; pointer steps 0,1,2,3; each instr_out equals the fetched address+0x100, with no skipped or duplicated word.
3. Set RESET_ADDR=32'hFFFFFFFF and perform one transfer -> pointer wraps to 0, and the next instr_out is the word at address 0.
4. redirect=1, redirect_addr=32'h40 on a core_en cycle while in WAIT -> the pending word is discarded, instr_valid stays 0, pointer=32'h40, and the next instr_out is mem[0x40]. Repeat with a simultaneous transfer in HOLD -> exactly one transfer is counted and the next fetch is from 0x40.
5. halt=1 together with redirect=1 on a core_en cycle -> halted=1 next cycle; instr_valid=0; pointer unchanged; later redirects and readies are ignored. Pulsing _reset=0 for one cycle -> all outputs return to reset values.
6. redirect=1 or halt=1 held only in cycles with core_en=0; also _reset=0 asserted in WAIT -> no effect from the non-core_en inputs; the reset restarts cleanly from RESET_ADDR with the divider count=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and default timing for the instruction fetch controller
package fetch_pkg;

  // Instruction word width seen on both the memory and the core side.
  localparam int INSTR_W     = 32;

  // Default core step period (clk cycles) and memory read latency.
  localparam int DEF_DIV     = 4;
  localparam int DEF_MEM_LAT = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    HOLD   = 3'd3,
    HALTED = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/clk_en_div.sv
// rtl/clk_en_div.sv - free-running one-cycle enable pulse every DIV clk cycles
//   clk     in  system clock
//   _reset  in  synchronous active-low reset
//   en      out high for one cycle when the internal count sits at DIV-1
module clk_en_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic _reset,
  output logic en
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_en;

  // r_en is registered but aligned with r_cnt: it is set on the edge where
  // r_cnt moves to DIV-1, so en and cnt==DIV-1 occupy the same cycle.
  always_ff @(posedge clk) begin
    if (!_reset) begin
      r_cnt <= '0;
      r_en  <= 1'b0;
    end else begin
      if (r_cnt == CNT_W'(DIV - 1)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_en <= (r_cnt == CNT_W'(DIV - 2));
    end
  end

  assign en = r_en;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer between instruction memory and the core
//   clk            in  system clock
//   _reset         in  synchronous active-low reset
//   instr_in       in  instruction word from memory (MEM_LAT cycles after ISSUE)
//   pointer        out word address to memory
//   core_en        out one-cycle core step enable, every DIV cycles
//   instr_out      out latched instruction to the core
//   instr_valid    out instr_out is valid
//   instr_ready    in  core accepts the instruction (core_en cycles only)
//   redirect       in  branch/jump request (core_en cycles only)
//   redirect_addr  in  redirect target
//   halt           in  stop fetching (core_en cycles only)
//   halted         out controller is halted until reset
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DIV        = DEF_DIV,
  parameter int                MEM_LAT    = DEF_MEM_LAT,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic               clk,
  input  logic               _reset,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [ADDR_W-1:0]  pointer,
  output logic               core_en,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               halt,
  output logic               halted
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);

  fetch_state_t       r_state;
  logic [ADDR_W-1:0]  r_pointer;
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;
  logic               r_halted;
  logic [LAT_W-1:0]   r_lat;

  logic w_core_en;
  logic w_halt_req;
  logic w_redirect_req;
  logic w_transfer;

  clk_en_div #(
    .DIV (DIV)
  ) u_div (
    .clk    (clk),
    ._reset (_reset),
    .en     (w_core_en)
  );

  // Core-side inputs only count in core step cycles. A redirect has no
  // meaning once halted, so it is masked there rather than in the FSM.
  assign w_halt_req     = w_core_en & halt;
  assign w_redirect_req = w_core_en & redirect & (r_state != HALTED);
  assign w_transfer     = w_core_en & r_valid & instr_ready;

  always_ff @(posedge clk) begin
    if (!_reset) begin
      r_state   <= IDLE;
      r_pointer <= RESET_ADDR;
      r_instr   <= '0;
      r_valid   <= 1'b0;
      r_halted  <= 1'b0;
      r_lat     <= '0;
    end else if (w_halt_req) begin
      // Halt wins over everything: any held word or in-flight read is dropped.
      r_state  <= HALTED;
      r_valid  <= 1'b0;
      r_halted <= 1'b1;
    end else if (w_redirect_req) begin
      // A coincident transfer is still consumed by the core; only the next
      // address changes. A pending capture is discarded, instr_out is kept.
      r_state   <= ISSUE;
      r_pointer <= redirect_addr;
      r_valid   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= ISSUE;
        end
        ISSUE: begin
          r_lat   <= LAT_W'(MEM_LAT);
          r_state <= WAIT;
        end
        WAIT: begin
          r_lat <= r_lat - LAT_W'(1);
          if (r_lat == LAT_W'(1)) begin
            r_instr <= instr_in;
            r_valid <= 1'b1;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_transfer) begin
            r_pointer <= r_pointer + ADDR_W'(1);
            r_valid   <= 1'b0;
            r_state   <= ISSUE;
          end
        end
        HALTED: begin
          r_valid  <= 1'b0;
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign pointer     = r_pointer;
  assign core_en     = w_core_en;
  assign instr_out   = r_instr;
  assign instr_valid = r_valid;
  assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic [31:0] instr_in, instr_in2;
  logic [31:0] pointer, pointer2;
  logic        core_en, core_en2;
  logic [31:0] instr_out, instr_out2;
  logic        instr_valid, instr_valid2;
  logic        instr_ready, instr_ready2;
  logic        redirect, redirect2;
  logic [31:0] redirect_addr, redirect_addr2;
  logic        halt, halt2;
  logic        halted, halted2;

  int total = 0;
  int bad   = 0;
  int xfers1 = 0;
  int xfers2 = 0;

  logic [63:0] q1[$];
  logic [63:0] q2[$];

  logic [31:0] p1_q;
  logic [31:0] p2_h [3];

  fetch_ctrl #(
    .ADDR_W(32), .DIV(4), .MEM_LAT(1), .RESET_ADDR(32'h0)
  ) dut (
    .clk(clk), ._reset(rst_n), .instr_in(instr_in), .pointer(pointer),
    .core_en(core_en), .instr_out(instr_out), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_addr(redirect_addr),
    .halt(halt), .halted(halted)
  );

  fetch_ctrl #(
    .ADDR_W(32), .DIV(4), .MEM_LAT(3), .RESET_ADDR(32'hFFFF_FFFF)
  ) dut2 (
    .clk(clk), ._reset(rst2_n), .instr_in(instr_in2), .pointer(pointer2),
    .core_en(core_en2), .instr_out(instr_out2), .instr_valid(instr_valid2),
    .instr_ready(instr_ready2), .redirect(redirect2), .redirect_addr(redirect_addr2),
    .halt(halt2), .halted(halted2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'hA000_0001 : a + 32'h100;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  // Memory model: the word for the address seen in cycle t appears in cycle
  // t+1 (dut) or t+3 (dut2), matching each instance's MEM_LAT.
  always @(negedge clk) begin
    p1_q    <= pointer;
    p2_h[0] <= pointer2;
    p2_h[1] <= p2_h[0];
    p2_h[2] <= p2_h[1];
  end

  always begin
    @(posedge clk);
    #1;
    instr_in  = mem_word(p1_q);
    instr_in2 = mem_word(p2_h[2]);
  end

  // Monitor: every transfer pops the next expected {address, word}.
  always @(negedge clk) begin
    if (instr_valid === 1'b1 && instr_ready === 1'b1 && core_en === 1'b1) begin
      xfers1 <= xfers1 + 1;
      check("xfer1_pending", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        logic [63:0] e;
        e = q1.pop_front();
        check("xfer1_addr", pointer, e[63:32]);
        check("xfer1_data", instr_out, e[31:0]);
      end
    end
    if (instr_valid2 === 1'b1 && instr_ready2 === 1'b1 && core_en2 === 1'b1) begin
      xfers2 <= xfers2 + 1;
      check("xfer2_pending", 32'(q2.size() > 0), 32'd1);
      if (q2.size() > 0) begin
        logic [63:0] e;
        e = q2.pop_front();
        check("xfer2_addr", pointer2, e[63:32]);
        check("xfer2_data", instr_out2, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reset1(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic reset2(input int n);
    rst2_n = 1'b0;
    repeat (n) tick();
    rst2_n = 1'b1;
  endtask

  task automatic wait_core_en(input bit sel, input string name);
    int b;
    b = 0;
    do begin
      tick();
      b++;
    end while (((sel ? core_en2 : core_en) !== 1'b1) && b < 32);
    if ((sel ? core_en2 : core_en) !== 1'b1) timeout(name);
  endtask

  task automatic wait_xfers(input bit sel, input int target, input string name);
    int b;
    b = 0;
    while ((sel ? xfers2 : xfers1) < target && b < 80) begin
      tick();
      b++;
    end
    if ((sel ? xfers2 : xfers1) < target) timeout(name);
  endtask

  task automatic wait_valid(input bit sel, input string name);
    int b;
    b = 0;
    while ((sel ? instr_valid2 : instr_valid) !== 1'b1 && b < 64) begin
      tick();
      b++;
    end
    if ((sel ? instr_valid2 : instr_valid) !== 1'b1) timeout(name);
  endtask

  // Called in cycle 0 after reset release with instr_ready low.
  task automatic observe_startup(input string tag);
    logic [11:0] mask;
    int          first_v;
    mask    = '0;
    first_v = -1;
    check({tag, "_rst_ptr"}, pointer, 32'h0);
    check({tag, "_rst_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_rst_halted"}, 32'(halted), 32'd0);
    check({tag, "_rst_core_en"}, 32'(core_en), 32'd0);
    check({tag, "_rst_instr"}, instr_out, 32'h0);
    for (int k = 0; k < 12; k++) begin
      mask[k] = core_en;
      if (instr_valid === 1'b1 && first_v < 0) begin
        first_v = k;
        check({tag, "_first_ptr"}, pointer, 32'h0);
        check({tag, "_first_data"}, instr_out, 32'hA000_0001);
      end
      tick();
    end
    check({tag, "_core_en_cycles"}, 32'(mask), 32'h888);
    check({tag, "_first_valid_cycle"}, 32'(first_v), 32'd3);
  endtask

  initial begin
    int b;
    int nbad;
    rst_n = 1'b0; rst2_n = 1'b0;
    instr_in = '0; instr_in2 = '0;
    instr_ready = 1'b0; instr_ready2 = 1'b0;
    redirect = 1'b0; redirect2 = 1'b0;
    redirect_addr = '0; redirect_addr2 = '0;
    halt = 1'b0; halt2 = 1'b0;
    tick();
    reset1(2);

    // Startup timing and first word.
    observe_startup("t1");

    // Back-to-back transfers, one per core_en.
    q1.push_back({32'h0, 32'hA000_0001});
    q1.push_back({32'h1, 32'h0000_0101});
    q1.push_back({32'h2, 32'h0000_0102});
    q1.push_back({32'h3, 32'h0000_0103});
    instr_ready = 1'b1;
    wait_xfers(1'b0, 4, "t2_xfers");
    instr_ready = 1'b0;
    wait_valid(1'b0, "t2_next_valid");
    check("t2_next_ptr", pointer, 32'h4);
    check("t2_next_data", instr_out, 32'h0000_0104);

    // Redirect together with a transfer in HOLD: one transfer, then 0x40.
    wait_core_en(1'b0, "t4b_core_en");
    q1.push_back({32'h4, 32'h0000_0104});
    q1.push_back({32'h40, 32'h0000_0140});
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_addr = 32'h40;
    tick();
    redirect = 1'b0;
    check("t4b_redir_ptr", pointer, 32'h40);
    check("t4b_redir_valid", 32'(instr_valid), 32'd0);
    wait_xfers(1'b0, 6, "t4b_xfers");
    instr_ready = 1'b0;

    // Halt beats a simultaneous redirect; later inputs are ignored.
    wait_core_en(1'b0, "t5_core_en");
    halt = 1'b1;
    redirect = 1'b1;
    redirect_addr = 32'h80;
    tick();
    halt = 1'b0;
    check("t5_halted", 32'(halted), 32'd1);
    check("t5_valid", 32'(instr_valid), 32'd0);
    check("t5_ptr", pointer, 32'h41);
    instr_ready = 1'b1;
    redirect_addr = 32'h90;
    nbad = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (halted !== 1'b1 || instr_valid !== 1'b0 || pointer !== 32'h41) nbad++;
    end
    check("t5_frozen_bad_cycles", 32'(nbad), 32'd0);
    redirect = 1'b0;
    instr_ready = 1'b0;
    reset1(1);
    check("t5_rst_ptr", pointer, 32'h0);
    check("t5_rst_valid", 32'(instr_valid), 32'd0);
    check("t5_rst_halted", 32'(halted), 32'd0);
    check("t5_rst_instr", instr_out, 32'h0);
    check("t5_rst_core_en", 32'(core_en), 32'd0);

    // Halt/redirect only outside core_en cycles must have no effect.
    q1.push_back({32'h0, 32'hA000_0001});
    q1.push_back({32'h1, 32'h0000_0101});
    q1.push_back({32'h2, 32'h0000_0102});
    q1.push_back({32'h3, 32'h0000_0103});
    instr_ready = 1'b1;
    redirect_addr = 32'h77;
    b = 0;
    while (xfers1 < 10 && b < 80) begin
      halt = ~core_en;
      redirect = ~core_en;
      tick();
      b++;
    end
    halt = 1'b0;
    redirect = 1'b0;
    instr_ready = 1'b0;
    if (xfers1 < 10) timeout("t6_xfers");
    check("t6_halted", 32'(halted), 32'd0);
    check("t6_ptr", pointer, 32'h4);
    // Now in ISSUE; step into WAIT and reset there.
    tick();
    reset1(1);
    observe_startup("t6");

    // Wrap from RESET_ADDR=FFFFFFFF on the MEM_LAT=3 instance.
    reset2(2);
    check("t3_rst_ptr", pointer2, 32'hFFFF_FFFF);
    check("t3_rst_valid", 32'(instr_valid2), 32'd0);
    q2.push_back({32'hFFFF_FFFF, 32'h0000_00FF});
    instr_ready2 = 1'b1;
    wait_xfers(1'b1, 1, "t3_xfer");
    instr_ready2 = 1'b0;
    check("t3_wrap_ptr", pointer2, 32'h0);
    wait_valid(1'b1, "t3_wrap_valid");
    check("t3_wrap_data", instr_out2, 32'hA000_0001);
    q2.push_back({32'h0, 32'hA000_0001});
    instr_ready2 = 1'b1;
    wait_xfers(1'b1, 2, "t3_xfer2");
    instr_ready2 = 1'b0;

    // Redirect on the core_en cycle that would otherwise capture the word.
    wait_core_en(1'b1, "t4_core_en");
    check("t4_in_wait_valid", 32'(instr_valid2), 32'd0);
    redirect2 = 1'b1;
    redirect_addr2 = 32'h40;
    tick();
    redirect2 = 1'b0;
    check("t4_redir_ptr", pointer2, 32'h40);
    check("t4_redir_valid", 32'(instr_valid2), 32'd0);
    check("t4_redir_instr_kept", instr_out2, 32'hA000_0001);
    q2.push_back({32'h40, 32'h0000_0140});
    instr_ready2 = 1'b1;
    wait_xfers(1'b1, 3, "t4_xfer");
    instr_ready2 = 1'b0;

    repeat (4) tick();
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q2_drained", 32'(q2.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    total++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
